// File: rtl/iterative_left_shifter.sv
// Multi-cycle left shifter/rotator: accepts an operand over a valid/ready handshake,
// shifts one bit per clock, and presents the result over a second valid/ready handshake.
module iterative_left_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_amount,
  input  logic               in_rotate,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] COUNT_ONE = SHAMT_W'(1);

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   data;
  logic [SHAMT_W-1:0] count;
  logic               rotate;
  logic               accept;
  logic               shift_step;
  logic               fill;

  assign accept     = (state == IDLE) && in_valid;
  assign shift_step = (state == SHIFT) && (count != '0);
  assign fill       = rotate ? data[WIDTH-1] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (count == '0) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand is captured only on the input handshake; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      data   <= '0;
      count  <= '0;
      rotate <= 1'b0;
    end else if (accept) begin
      data   <= in_data;
      count  <= in_amount;
      rotate <= in_rotate;
    end else if (shift_step) begin
      data   <= {data[WIDTH-2:0], fill};
      count  <= count - COUNT_ONE;
    end else begin
      data   <= data;
      count  <= count;
      rotate <= rotate;
    end
  end

  // All handshake outputs decode the state register only, so no input-to-output paths exist.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = data;

endmodule

// File: doc/iterative_left_shifter.md
# iterative_left_shifter

Multi-cycle left shifter/rotator. It is the sequential counterpart to the combinational right barrel shifter in the datapath library. It accepts an operand and a shift amount over a valid/ready handshake, then shifts left one bit position per clock, either logically (zero fill) or as a rotate. The result is presented over a second valid/ready handshake. It is used where area matters more than latency, and it gives the verification team a left/rotate reference against which to cross-check the right shifter.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; must be ≥ 2.
- SHAMT_W, default $clog2(WIDTH) (3 for the default WIDTH): shift-amount width.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid, input, 1: the input operand is valid.
- in_ready, output, 1: the block can accept an operand.
- in_data, input, WIDTH: operand to shift.
- in_amount, input, SHAMT_W: shift distance, 0..WIDTH-1.
- in_rotate, input, 1: 1 = rotate left (MSB wraps to LSB); 0 = logical left (LSB filled with 0).
- out_valid, output, 1: out_data holds a completed result.
- out_ready, input, 1: the consumer accepts the result.
- out_data, output, WIDTH: shift result.
- busy, output, 1: high in SHIFT and DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid && in_ready: capture in_data into the data register, in_amount into the counter, in_rotate into the mode flag; go to SHIFT.
- SHIFT:
  - in_ready=0.
  - If counter==0: go to DONE with no data change.
  - Else: data ← {data[WIDTH-2:0], fill}, where fill = data[WIDTH-1] if rotating, else 0. Counter decrements by 1.
- DONE:
  - out_valid=1, out_data = data register.
  - On out_ready: go to IDLE.
  - Without out_ready: hold. out_data stays stable and out_valid stays high (no retraction).
- Input values are ignored outside the IDLE handshake. Changes to in_* during SHIFT/DONE have no effect.
- Amount 0 is legal: the result equals the operand, after the minimum latency.
- Arithmetic:
  - Logical shift by N gives (in_data << N) truncated to WIDTH.
  - Rotate by N gives (in_data << N) | (in_data >> (WIDTH-N)) for N>0.
- Only one operation is in flight at a time; there is no pipelining.
- Reset mid-operation (SHIFT or DONE): the operation is aborted with no result produced. Next cycle: IDLE, out_valid=0, out_data=0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0. Data register and counter = 0.
- Acceptance at edge E0. Shift edges are E1..EN. DONE is entered at edge E(N+1), so out_valid is first visible in the cycle after E(N+1).
  - Latency is N+1 cycles from acceptance to out_valid.
  - Minimum latency is 1 cycle (N=0). Maximum is WIDTH cycles.
- Output handshake at edge F returns the FSM to IDLE; in_ready is high in the cycle after F.
  - Earliest back-to-back acceptance is the edge after F.
  - Initiation interval is N+3 cycles when out_ready is held high.
- in_ready is purely a function of state (IDLE). There is no combinational path from out_ready to in_ready, nor from in_valid to out_valid.
- rst has priority over every handshake on the same edge.

## Test plan
- Logical shift: in_data=8'b00000001, amount=4, rotate=0, out_ready=1 → out_data=8'b00010000; out_valid rises 5 cycles after acceptance; busy high throughout.
- Rotate wrap: in_data=8'b10000001, amount=1, rotate=1 → 8'b00000011. Then in_data=8'b10000000, amount=7, rotate=0 → 8'b00000000. Finally in_data=8'b00000001, amount=7, rotate=0 → 8'b10000000.
- Zero amount: in_data=8'hA5, amount=0 → 8'hA5 after 1 cycle; in_ready stays low until the output handshake completes.
- Backpressure: out_ready=0 for 10 cycles after DONE → out_valid stays 1 and out_data stays stable; in_ready stays 0 even with in_valid=1. Raising out_ready → IDLE on the next edge, and the following operand is accepted one edge later.
- Input isolation: change in_data/in_amount/in_rotate every cycle during SHIFT → result matches only the captured operand.
- Reset mid-shift: assert rst for 1 cycle during SHIFT of 8'hFF by 6 → next cycle in_ready=1, out_valid=0, out_data=0, busy=0, and no result is ever produced. A new operation afterwards completes correctly.
